// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pooling controller.
// Holds the pixel width, the row-phase state encoding and a 2-input max helper.
package pool_pkg;

    localparam int pix_w = 8;

    typedef logic [pix_w-1:0] pixel_t;

    // Even input rows fill the line buffer; odd rows complete windows.
    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_POOL = 1'b1
    } pool_state_t;

    function automatic pixel_t max2(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool2x2_ctrl_if.sv
// Pixel stream interface for pool2x2_ctrl: raster input side and pooled output side.
// Handshake: a beat moves when valid & ready are both high on a rising clk edge; a
// producer holds valid and payload stable until that edge, and ready may depend on valid.
interface pool2x2_ctrl_if;
    import pool_pkg::*;

    logic   v_i;
    pixel_t data_i;
    logic   ready_o;
    logic   v_o;
    pixel_t data_o;
    logic   last_o;
    logic   ready_i;

    modport slave (
        input  v_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output v_o,
        output data_o,
        output last_o
    );

    modport master (
        output v_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  v_o,
        input  data_o,
        input  last_o
    );

endinterface

// File: rtl/comp.sv
// 4:1 unsigned max comparator, purely combinational.
// Ties resolve to the shared value since max of equal operands is that operand.
module comp
    import pool_pkg::*;
(
    input  pixel_t a,
    input  pixel_t b,
    input  pixel_t c,
    input  pixel_t d,
    output pixel_t result
);

    assign result = max2(max2(a, b), max2(c, d));

endmodule

// File: rtl/pool2x2_linebuf.sv
// One-row pixel line buffer: single write port, two asynchronous read ports.
// Contents are not reset; every entry is written during the even row before it is read.
module pool2x2_linebuf
    import pool_pkg::*;
#(
    parameter int width_p = 28,
    parameter int addr_w  = $clog2(width_p)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic [addr_w-1:0] rd_addr_lo,
    input  logic [addr_w-1:0] rd_addr_hi,
    output pixel_t            rd_data_lo,
    output pixel_t            rd_data_hi
);

    pixel_t mem [width_p];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_lo = mem[rd_addr_lo];
    assign rd_data_hi = mem[rd_addr_hi];

endmodule

// File: rtl/pool2x2_ctrl.sv
// 2x2 max-pooling controller over a raster pixel stream with one output register.
// Even rows are buffered; odd rows pair with the buffer to emit one pooled pixel per window.
module pool2x2_ctrl
    import pool_pkg::*;
#(
    parameter int width_p  = 28,
    parameter int height_p = 28
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    pool2x2_ctrl_if.slave         bus,
    output pool_state_t           dbg_state
);

    localparam int cw = $clog2(width_p);
    localparam int rw = $clog2(height_p);
    localparam logic [cw-1:0] col_last = cw'(width_p - 1);
    localparam logic [rw-1:0] row_last = rw'(height_p - 1);

    logic [cw-1:0] col;
    logic [rw-1:0] row;
    pool_state_t   state;
    pixel_t        prev;
    pixel_t        lb_lo;
    pixel_t        lb_hi;
    pixel_t        win_max;

    logic   v_q;
    pixel_t data_q;
    logic   last_q;

    logic ready;
    logic xfer;
    logic col_end;
    logic row_end;
    logic win_done;

    assign col_end = (col == col_last);
    assign row_end = (row == row_last);

    // Filling never touches the output register, so it accepts even while output stalls.
    assign ready    = (state == S_FILL) | ~v_q | bus.ready_i;
    assign xfer     = bus.v_i & ready;
    assign win_done = xfer & (state == S_POOL) & col[0];

    pool2x2_linebuf #(
        .width_p (width_p),
        .addr_w  (cw)
    ) u_linebuf (
        .clk        (clk_i),
        .wr_en      (xfer & (state == S_FILL)),
        .wr_addr    (col),
        .wr_data    (bus.data_i),
        .rd_addr_lo (col - cw'(1)),
        .rd_addr_hi (col),
        .rd_data_lo (lb_lo),
        .rd_data_hi (lb_hi)
    );

    comp u_comp (
        .a      (bus.data_i),
        .b      (prev),
        .c      (lb_lo),
        .d      (lb_hi),
        .result (win_max)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col   <= '0;
            row   <= '0;
            state <= S_FILL;
        end else if (xfer) begin
            if (col_end) begin
                col   <= '0;
                row   <= row_end ? '0 : row + rw'(1);
                state <= (state == S_FILL) ? S_POOL : S_FILL;
            end else begin
                col <= col + cw'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev <= '0;
        end else if (xfer && (state == S_POOL) && !col[0]) begin
            prev <= bus.data_i;
        end
    end

    // A completing window may only arrive when the register is empty or draining.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (win_done) begin
            v_q    <= 1'b1;
            data_q <= win_max;
            last_q <= row_end & col_end;
        end else if (v_q && bus.ready_i) begin
            v_q    <= 1'b0;
            last_q <= 1'b0;
        end
    end

    assign bus.ready_o = ready;
    assign bus.v_o     = v_q;
    assign bus.data_o  = data_q;
    assign bus.last_o  = last_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_pool2x2_ctrl.sv
// Bench for pool2x2_ctrl: a 4x2 instance for directed vectors and a 28x28 instance
// driven with random gaps and output throttling against a frame reference model.
module tb_pool2x2_ctrl;
    import pool_pkg::*;

    logic clk;
    logic rst;
    logic l_throttle;
    int   total;
    int   bad;

    pool_state_t st_s;
    pool_state_t st_l;

    logic [8:0] exp_s_q[$];
    logic [8:0] exp_l_q[$];

    logic [7:0] pix [28*28];

    pool2x2_ctrl_if bus_s ();
    pool2x2_ctrl_if bus_l ();

    pool2x2_ctrl #(.width_p(4), .height_p(2)) dut_s (
        .clk_i     (clk),
        .reset_i   (rst),
        .bus       (bus_s),
        .dbg_state (st_s)
    );

    pool2x2_ctrl dut_l (
        .clk_i     (clk),
        .reset_i   (rst),
        .bus       (bus_l),
        .dbg_state (st_l)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitors
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus_s.v_o === 1'b1 && bus_s.ready_i === 1'b1) begin
                if (exp_s_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL s_unexpected: got data %0d last %0d, expected no output",
                             bus_s.data_o, bus_s.last_o);
                end else begin
                    e = exp_s_q.pop_front();
                    check("s_out", {23'd0, bus_s.last_o, bus_s.data_o}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus_l.v_o === 1'b1 && bus_l.ready_i === 1'b1) begin
                if (exp_l_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL l_unexpected: got data %0d last %0d, expected no output",
                             bus_l.data_o, bus_l.last_o);
                end else begin
                    e = exp_l_q.pop_front();
                    check("l_out", {23'd0, bus_l.last_o, bus_l.data_o}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (l_throttle) bus_l.ready_i = ($urandom_range(0, 2) != 0);
            else            bus_l.ready_i = 1'b1;
        end
    end

    // drivers
    task automatic s_send(input logic [7:0] d);
        bit acc = 1'b0;
        bus_s.v_i    = 1'b1;
        bus_s.data_i = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus_s.ready_o;
            @(posedge clk);
            #1;
        end
        bus_s.v_i = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL s_send_timeout: pixel %0d not accepted, required within 50 cycles", d);
        end
    endtask

    task automatic l_send(input logic [7:0] d);
        bit acc = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bus_l.v_i    = 1'b1;
        bus_l.data_i = d;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = bus_l.ready_o;
            @(posedge clk);
            #1;
        end
        bus_l.v_i = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL l_send_timeout: pixel %0d not accepted, required within 200 cycles", d);
        end
    endtask

    task automatic s_pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic s_send_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                                input logic [7:0] p6, input logic [7:0] p7,
                                input logic [7:0] out0, input logic [7:0] out1);
        logic [7:0] f [8];
        f = '{p0, p1, p2, p3, p4, p5, p6, p7};
        for (int i = 0; i < 8; i++) begin
            s_send(f[i]);
            if (i == 5) begin
                check("s_lat_v0", {31'd0, bus_s.v_o}, 32'd1);
                check("s_lat_d0", {24'd0, bus_s.data_o}, {24'd0, out0});
                check("s_lat_l0", {31'd0, bus_s.last_o}, 32'd0);
            end else if (i == 7) begin
                check("s_lat_v1", {31'd0, bus_s.v_o}, 32'd1);
                check("s_lat_d1", {24'd0, bus_s.data_o}, {24'd0, out1});
                check("s_lat_l1", {31'd0, bus_s.last_o}, 32'd1);
            end else begin
                check("s_idle_v", {31'd0, bus_s.v_o}, 32'd0);
            end
        end
    endtask

    // main stimulus
    initial begin
        int fr;
        rst          = 1'b1;
        l_throttle   = 1'b0;
        total        = 0;
        bad          = 0;
        bus_s.v_i    = 1'b0;
        bus_s.data_i = '0;
        bus_s.ready_i = 1'b1;
        bus_l.v_i    = 1'b0;
        bus_l.data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("s_rst_v", {31'd0, bus_s.v_o}, 32'd0);
        check("s_rst_d", {24'd0, bus_s.data_o}, 32'd0);
        check("s_rst_l", {31'd0, bus_s.last_o}, 32'd0);
        check("s_rst_rdy", {31'd0, bus_s.ready_o}, 32'd1);
        check("s_rst_st", {31'd0, st_s}, {31'd0, S_FILL});
        check("l_rst_v", {31'd0, bus_l.v_o}, 32'd0);
        check("l_rst_st", {31'd0, st_l}, {31'd0, S_FILL});

        // 1..8 streamed with ready_i high: 6 then 8, one cycle after pixels 6 and 8
        exp_s_q.push_back({1'b0, 8'd6});
        exp_s_q.push_back({1'b1, 8'd8});
        s_send_frame(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd6, 8'd8);
        @(posedge clk);
        #1;
        check("s_drain_v", {31'd0, bus_s.v_o}, 32'd0);
        check("s_frame_st", {31'd0, st_s}, {31'd0, S_FILL});

        // output stall for three cycles while the next odd-row pixel waits
        exp_s_q.push_back({1'b0, 8'd6});
        exp_s_q.push_back({1'b1, 8'd8});
        for (int i = 1; i <= 6; i++) s_send(8'(i));
        check("s_pool_st", {31'd0, st_s}, {31'd0, S_POOL});
        bus_s.ready_i = 1'b0;
        bus_s.v_i     = 1'b1;
        bus_s.data_i  = 8'd7;
        repeat (3) begin
            @(negedge clk);
            check("s_hold_v", {31'd0, bus_s.v_o}, 32'd1);
            check("s_hold_d", {24'd0, bus_s.data_o}, 32'd6);
            check("s_hold_rdy", {31'd0, bus_s.ready_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus_s.ready_i = 1'b1;
        s_send(8'd7);
        check("s_after_stall_v", {31'd0, bus_s.v_o}, 32'd0);
        s_send(8'd8);
        check("s_after_stall_d", {24'd0, bus_s.data_o}, 32'd8);
        check("s_after_stall_l", {31'd0, bus_s.last_o}, 32'd1);
        @(posedge clk);
        #1;

        // ties and extreme values
        exp_s_q.push_back({1'b0, 8'd200});
        exp_s_q.push_back({1'b1, 8'd255});
        s_send_frame(8'd200, 8'd200, 8'd0, 8'd255, 8'd200, 8'd200, 8'd0, 8'd0, 8'd200, 8'd255);
        @(posedge clk);
        #1;

        // reset after five pixels
        for (int i = 1; i <= 5; i++) s_send(8'(i));
        s_pulse_reset();
        check("s_mid_rst_v", {31'd0, bus_s.v_o}, 32'd0);
        check("s_mid_rst_d", {24'd0, bus_s.data_o}, 32'd0);
        check("s_mid_rst_rdy", {31'd0, bus_s.ready_o}, 32'd1);
        check("s_mid_rst_st", {31'd0, st_s}, {31'd0, S_FILL});

        // reset while an output is pending must drop it
        bus_s.ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) s_send(8'(i));
        check("s_pend_v", {31'd0, bus_s.v_o}, 32'd1);
        check("s_pend_d", {24'd0, bus_s.data_o}, 32'd6);
        check("s_pend_rdy", {31'd0, bus_s.ready_o}, 32'd0);
        s_pulse_reset();
        bus_s.ready_i = 1'b1;
        check("s_pend_rst_v", {31'd0, bus_s.v_o}, 32'd0);
        check("s_pend_rst_d", {24'd0, bus_s.data_o}, 32'd0);

        exp_s_q.push_back({1'b0, 8'd14});
        exp_s_q.push_back({1'b1, 8'd16});
        s_send_frame(8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd14, 8'd16);
        @(posedge clk);
        #1;

        // two back-to-back 28x28 frames with random gaps and throttle
        l_throttle = 1'b1;
        for (fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < 28 * 28; i++) begin
                pix[i] = ($urandom_range(0, 3) == 0) ? 8'd100 : 8'($urandom_range(0, 255));
            end
            for (int r = 0; r < 14; r++) begin
                for (int c = 0; c < 14; c++) begin
                    logic [7:0] m;
                    m = pix[(2*r)*28 + 2*c];
                    if (pix[(2*r)*28 + 2*c + 1] > m)   m = pix[(2*r)*28 + 2*c + 1];
                    if (pix[(2*r+1)*28 + 2*c] > m)     m = pix[(2*r+1)*28 + 2*c];
                    if (pix[(2*r+1)*28 + 2*c + 1] > m) m = pix[(2*r+1)*28 + 2*c + 1];
                    exp_l_q.push_back({(r == 13 && c == 13), m});
                end
            end
            for (int i = 0; i < 28 * 28; i++) l_send(pix[i]);
        end
        l_throttle = 1'b0;

        for (int k = 0; k < 200 && (exp_l_q.size() != 0 || exp_s_q.size() != 0); k++) begin
            @(posedge clk);
            #1;
        end
        check("l_queue_left", exp_l_q.size(), 32'd0);
        check("s_queue_left", exp_s_q.size(), 32'd0);
        @(posedge clk);
        #1;
        check("l_final_v", {31'd0, bus_l.v_o}, 32'd0);
        check("l_final_st", {31'd0, st_l}, {31'd0, S_FILL});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
